// File: rtl/pipe_latch.sv
// Handshaked inter-stage pipeline register with flush masking and a saturating stall counter.
// Define PIPE_LATCH_SKID_EN for a 2-entry skid buffer with a registered ready_o.
module pipe_latch #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] CTRL_MASK = 'h0000_000F,
  parameter int                CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ready_i,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  stall_cnt_o,
  input  logic              clr_cnt_i
);

  // Handshake: a bundle moves across a boundary on a rising edge where valid
  // and ready are both high; valid never drops without a deliver or a flush.
  logic accept;
  logic deliver;

  assign accept  = valid_i && ready_o;
  assign deliver = valid_o && ready_i;

`ifdef PIPE_LATCH_SKID_EN

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] skid_d, skid_d_n;
  logic              skid_v;

  assign valid_o = (state_q != ST_EMPTY);
  assign skid_v  = (state_q == ST_FULL);
  assign ready_o = !skid_v;
  assign data_o  = data_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      skid_d  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      skid_d  <= skid_d_n;
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    skid_d_n = skid_d;
    if (flush_i) begin
      state_d  = ST_EMPTY;
      data_d   = data_q & ~CTRL_MASK;
      skid_d_n = skid_d & ~CTRL_MASK;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            data_d  = data_i;
          end
        end
        ST_ONE: begin
          if (accept && ready_i) begin
            data_d = data_i;
          end else if (accept) begin
            state_d  = ST_FULL;
            skid_d_n = data_i;
          end else if (deliver) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // ready_o is low here, so only the drain of main is possible
          if (deliver) begin
            state_d = ST_ONE;
            data_d  = skid_d;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

`else

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ready_o = !valid_q || ready_i;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      data_q  <= data_q & ~CTRL_MASK;
    end else if (accept) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (deliver) begin
      valid_q <= 1'b0;
    end
  end

`endif

  logic [CNT_W-1:0] cnt_q;

  assign stall_cnt_o = cnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else if (clr_cnt_i) begin
      cnt_q <= '0;
    end else if (valid_o && !ready_i && !flush_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule
